// File: rtl/bubble_sort_ctrl.sv
// bubble_sort_ctrl
// In-place ascending bubble sort over RAM addresses 0..count-1. The block
// acts as the only initiator on a single-port RAM whose read data appears
// one cycle after the read strobe.
//
// Build option: define BUBBLE_SORT_EARLY_EXIT_EN to finish as soon as a
// whole pass completes without a swap. Without it, count-1 full passes
// always run, so run time depends only on count and the number of swaps.
// The port list is the same in both builds.

module bubble_sort_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_CAP_B,
    S_CMP,
    S_WR_A,
    S_WR_B,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_TWO = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t              r_state;
  state_t              w_next;

  logic [ADDR_W-1:0]   r_i;        // inner index (left element of the pair)
  logic [ADDR_W:0]     r_last;     // last compare index + 1 for this pass
  logic [DATA_W-1:0]   r_a;        // word at r_i
  logic [DATA_W-1:0]   r_b;        // word at r_i+1
  logic                r_swapped;  // any swap in the current pass
  logic [ADDR_W-1:0]   r_addr_q;   // address held while strobes are idle
  logic [DATA_W-1:0]   r_wdata_q;  // write data held while strobes are idle

  logic [ADDR_W:0]     w_count_clamped;
  logic                w_count_small;
  logic [ADDR_W:0]     w_i_ext;    // r_i + 1 without wrap-around
  logic [ADDR_W-1:0]   w_i_plus1;
  logic                w_pass_more;
  logic                w_last_pass;
  logic                w_early_exit;
  logic                w_finish;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;

  // Counts larger than the RAM depth are treated as a full-array sort.
  assign w_count_clamped = (count > CNT_MAX) ? CNT_MAX : count;
  assign w_count_small   = (w_count_clamped < CNT_TWO);

  assign w_i_ext     = {1'b0, r_i} + CNT_ONE;
  assign w_i_plus1   = w_i_ext[ADDR_W-1:0];
  assign w_pass_more = (w_i_ext < r_last);
  assign w_last_pass = (r_last == CNT_ONE);

`ifdef BUBBLE_SORT_EARLY_EXIT_EN
  // A clean pass means the array is already in order.
  assign w_early_exit = ~r_swapped;
`else
  // Full passes always run; the swap flag is tracked but never ends a sort.
  assign w_early_exit = 1'b0 & r_swapped;
`endif

  assign w_finish = w_last_pass | w_early_exit;

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign mem_addr  = w_addr;
  assign mem_wdata = w_wdata;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignment so every register
      // samples pre-edge values and simulation matches the synthesized flops.
      r_state <= w_next;
    end
  end

  // Next-state decode and RAM strobes; address/data hold when idle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_next  = r_state;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    w_addr  = r_addr_q;
    w_wdata = r_wdata_q;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_count_small ? S_DONE : S_RD_A;
        end
      end
      S_RD_A: begin
        mem_rd = 1'b1;
        w_addr = r_i;
        w_next = S_RD_B;
      end
      S_RD_B: begin
        mem_rd = 1'b1;
        w_addr = w_i_plus1;
        w_next = S_CAP_B;
      end
      S_CAP_B: begin
        w_next = S_CMP;
      end
      S_CMP: begin
        // Strict compare: equal neighbours stay where they are.
        w_next = (r_a > r_b) ? S_WR_A : S_NEXT;
      end
      S_WR_A: begin
        mem_wr  = 1'b1;
        w_addr  = r_i;
        w_wdata = r_b;
        w_next  = S_WR_B;
      end
      S_WR_B: begin
        mem_wr  = 1'b1;
        w_addr  = w_i_plus1;
        w_wdata = r_a;
        w_next  = S_NEXT;
      end
      S_NEXT: begin
        if (w_pass_more) begin
          w_next = S_RD_A;
        end else if (w_finish) begin
          w_next = S_DONE;
        end else begin
          w_next = S_RD_A;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Hold registers so the RAM address/data pins stay stable between accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_q  <= '0;
      r_wdata_q <= '0;
    end else begin
      r_addr_q  <= w_addr;
      r_wdata_q <= w_wdata;
    end
  end

  // Sort datapath: indices, operand capture and per-pass swap tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i       <= '0;
      r_last    <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_swapped <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !w_count_small) begin
            r_i       <= '0;
            r_last    <= w_count_clamped - CNT_ONE;
            r_swapped <= 1'b0;
          end
        end
        S_RD_B: begin
          // Data for address r_i, registered by the RAM during RD_A.
          r_a <= mem_rdata;
        end
        S_CAP_B: begin
          // Data for address r_i+1, registered by the RAM during RD_B.
          r_b <= mem_rdata;
        end
        S_WR_A: begin
          r_swapped <= 1'b1;
        end
        S_NEXT: begin
          if (w_pass_more) begin
            r_i <= w_i_plus1;
          end else if (!w_finish) begin
            r_last    <= r_last - CNT_ONE;
            r_i       <= '0;
            r_swapped <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Directed self-checking bench for bubble_sort_ctrl with a behavioural
// single-port RAM (read data registered on the read edge).

module tb_bubble_sort_ctrl;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

`ifdef BUBBLE_SORT_EARLY_EXIT_EN
  localparam int PRESORT_CYC = 16;
  localparam int PRESORT_RD  = 6;
`else
  localparam int PRESORT_CYC = 31;
  localparam int PRESORT_RD  = 12;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   count = '0;
  logic              busy;
  logic              done;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  logic [DATA_W-1:0] ram      [DEPTH];
  logic [DATA_W-1:0] init_img [DEPTH];
  logic              load_req = 1'b0;

  int checks = 0;
  int errors = 0;

  bubble_sort_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: bulk preload, write, and registered read.
  always @(posedge clk) begin
    if (load_req) begin
      ram <= init_img;
    end else begin
      if (mem_wr) ram[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= ram[mem_addr];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic load_ram();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic fill_img(input int v0, input int v1, input int v2, input int v3);
    for (int k = 0; k < DEPTH; k++) init_img[k] = DATA_W'(16'h7777);
    init_img[0] = DATA_W'(v0);
    init_img[1] = DATA_W'(v1);
    init_img[2] = DATA_W'(v2);
    init_img[3] = DATA_W'(v3);
  endtask

  // Pulses start, then walks cycles (cycle 1 = first after the sampling edge)
  // until done, tallying strobes. pulse_at>0 injects a stray start mid-sort.
  task automatic run_sort(input int n, input int limit, input int pulse_at,
                          output int cyc, output int rd_c, output int wr_c,
                          output int busy_c, output int ovl, output bit seen);
    rd_c = 0; wr_c = 0; busy_c = 0; ovl = 0; seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    count = (ADDR_W+1)'(n);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc <= limit) begin
      if (start) start = 1'b0;
      rd_c   += int'(mem_rd);
      wr_c   += int'(mem_wr);
      busy_c += int'(busy);
      if (mem_rd && mem_wr) ovl++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (cyc == pulse_at) begin
        start = 1'b1;
        count = (ADDR_W+1)'(2);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles (count=%0d)", limit, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({busy, done, mem_rd, mem_wr, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b rd=%b wr=%b addr=%h wdata=%h, want all 0",
               busy, done, mem_rd, mem_wr, mem_addr, mem_wdata);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, mem_rd, mem_wr, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: got busy=%b done=%b rd=%b wr=%b addr=%h wdata=%h, want all 0",
               busy, done, mem_rd, mem_wr, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_reverse(input int pulse_at, input string tag);
    int cyc, rd_c, wr_c, busy_c, ovl;
    bit seen;
    logic [DATA_W-1:0] exp [4];
    exp[0] = 16'd1; exp[1] = 16'd2; exp[2] = 16'd3; exp[3] = 16'd4;
    fill_img(4, 3, 2, 1);
    load_ram();
    run_sort(4, 200, pulse_at, cyc, rd_c, wr_c, busy_c, ovl, seen);
    checks++;
    if (cyc !== 43) begin
      errors++; $display("FAIL %s_done_cycle: got %0d, want 43", tag, cyc);
    end
    checks++;
    if (wr_c !== 12 || rd_c !== 12 || ovl !== 0) begin
      errors++; $display("FAIL %s_strobes: got wr=%0d rd=%0d overlap=%0d, want 12 12 0", tag, wr_c, rd_c, ovl);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ram[k] !== exp[k]) begin
        errors++; $display("FAIL %s_ram%0d: got %0d, want %0d", tag, k, ram[k], exp[k]);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL %s_return_idle: got busy=%b done=%b, want 0 0", tag, busy, done);
    end
  endtask

  task automatic test_presorted();
    int cyc, rd_c, wr_c, busy_c, ovl;
    bit seen;
    fill_img(1, 2, 3, 4);
    load_ram();
    run_sort(4, 200, 0, cyc, rd_c, wr_c, busy_c, ovl, seen);
    checks++;
    if (cyc !== PRESORT_CYC) begin
      errors++; $display("FAIL presorted_done_cycle: got %0d, want %0d", cyc, PRESORT_CYC);
    end
    checks++;
    if (wr_c !== 0 || rd_c !== PRESORT_RD) begin
      errors++; $display("FAIL presorted_strobes: got wr=%0d rd=%0d, want 0 %0d", wr_c, rd_c, PRESORT_RD);
    end
    checks++;
    if (ram[0] !== 16'd1 || ram[1] !== 16'd2 || ram[2] !== 16'd3 || ram[3] !== 16'd4) begin
      errors++; $display("FAIL presorted_ram: got %0d %0d %0d %0d, want 1 2 3 4", ram[0], ram[1], ram[2], ram[3]);
    end
  endtask

  task automatic test_duplicates();
    int cyc, rd_c, wr_c, busy_c, ovl;
    bit seen;
    fill_img(5, 5, 2, 16'h7777);
    load_ram();
    run_sort(3, 200, 0, cyc, rd_c, wr_c, busy_c, ovl, seen);
    checks++;
    if (cyc !== 20 || wr_c !== 4) begin
      errors++; $display("FAIL dup_timing: got cycle=%0d wr=%0d, want 20 4", cyc, wr_c);
    end
    checks++;
    if (ram[0] !== 16'd2 || ram[1] !== 16'd5 || ram[2] !== 16'd5 || ram[3] !== 16'h7777) begin
      errors++; $display("FAIL dup_ram: got %0d %0d %0d %h, want 2 5 5 7777", ram[0], ram[1], ram[2], ram[3]);
    end
  endtask

  task automatic test_small_counts();
    int cyc, rd_c, wr_c, busy_c, ovl;
    bit seen;
    fill_img(9, 8, 7, 6);
    load_ram();
    for (int n = 1; n >= 0; n--) begin
      run_sort(n, 20, 0, cyc, rd_c, wr_c, busy_c, ovl, seen);
      checks++;
      if (cyc !== 1 || rd_c !== 0 || wr_c !== 0 || busy_c !== 1) begin
        errors++;
        $display("FAIL small_count%0d: got cycle=%0d rd=%0d wr=%0d busy_cycles=%0d, want 1 0 0 1",
                 n, cyc, rd_c, wr_c, busy_c);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ram[0] !== 16'd9 || ram[1] !== 16'd8) begin
        errors++; $display("FAIL small_count%0d_after: got busy=%b ram0=%0d ram1=%0d, want 0 9 8", n, busy, ram[0], ram[1]);
      end
    end
  endtask

  task automatic test_random();
    int cyc, rd_c, wr_c, busy_c, ovl, inv, bad;
    bit seen;
    logic [DATA_W-1:0] srt [16];
    logic [DATA_W-1:0] tmp;
    for (int k = 0; k < DEPTH; k++) init_img[k] = DATA_W'(16'h7777);
    for (int k = 0; k < 16; k++) init_img[k] = DATA_W'($urandom_range(0, 65535));
    init_img[5] = init_img[11];  // guarantee at least one duplicate pair
    inv = 0;
    for (int p = 0; p < 16; p++)
      for (int q = p + 1; q < 16; q++)
        if (init_img[p] > init_img[q]) inv++;
    for (int k = 0; k < 16; k++) srt[k] = init_img[k];
    for (int p = 1; p < 16; p++) begin
      tmp = srt[p];
      for (int q = p - 1; q >= 0; q--) begin
        if (srt[q] <= tmp) break;
        srt[q + 1] = srt[q];
        srt[q] = tmp;
      end
    end
    load_ram();
    run_sort(16, 2000, 0, cyc, rd_c, wr_c, busy_c, ovl, seen);
    checks++;
    if (wr_c !== 2 * inv || ovl !== 0) begin
      errors++; $display("FAIL random_writes: got wr=%0d overlap=%0d, want %0d 0", wr_c, ovl, 2 * inv);
    end
`ifndef BUBBLE_SORT_EARLY_EXIT_EN
    checks++;
    if (cyc !== 5 * 120 + 2 * inv + 1) begin
      errors++; $display("FAIL random_done_cycle: got %0d, want %0d", cyc, 5 * 120 + 2 * inv + 1);
    end
`endif
    bad = 0;
    for (int k = 0; k < 16; k++) if (ram[k] !== srt[k]) bad++;
    if (ram[16] !== 16'h7777) bad++;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL random_ram: got %0d wrong words, want 0", bad);
    end
  endtask

  // Oversized count must sort the whole RAM: pass 1 stops at address 1023.
  task automatic test_clamp();
    int wr_c, rd_top;
    for (int k = 0; k < DEPTH; k++) init_img[k] = DATA_W'(k);
    load_ram();
    @(negedge clk);
    start = 1'b1;
    count = '1;
    @(negedge clk);
    start = 1'b0;
    wr_c = 0; rd_top = 0;
    for (int c = 1; c <= 5115; c++) begin
      wr_c += int'(mem_wr);
      if (mem_rd && mem_addr == 10'd1023) rd_top++;
      @(negedge clk);
    end
    checks++;
    if (wr_c !== 0 || rd_top !== 1) begin
      errors++; $display("FAIL clamp_pass1: got wr=%0d top_reads=%0d, want 0 1", wr_c, rd_top);
    end
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL clamp_pass_end: got done=%b, want 1", done);
    end
`else
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 10'd0) begin
      errors++; $display("FAIL clamp_pass_end: got rd=%b addr=%0d, want 1 0", mem_rd, mem_addr);
    end
`endif
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_sort();
    fill_img(4, 3, 2, 1);
    load_ram();
    @(negedge clk);
    start = 1'b1;
    count = (ADDR_W+1)'(4);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);  // now in cycle 12: WR_A of compare at i=1
    checks++;
    if (mem_wr !== 1'b1 || mem_addr !== 10'd1 || mem_wdata !== 16'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_wr_a: got wr=%b addr=%0d wdata=%0d busy=%b, want 1 1 2 1",
                         mem_wr, mem_addr, mem_wdata, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, mem_rd, mem_wr, mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL mid_reset_async: got busy=%b done=%b rd=%b wr=%b addr=%h wdata=%h, want all 0",
                         busy, done, mem_rd, mem_wr, mem_addr, mem_wdata);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, mem_rd, mem_wr, mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL mid_reset_hold: got busy=%b done=%b rd=%b wr=%b addr=%h wdata=%h, want all 0",
                         busy, done, mem_rd, mem_wr, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_reverse(0, "reverse");
    test_presorted();
    test_duplicates();
    test_small_counts();
    test_random();
    test_clamp();
    test_reset_mid_sort();
    test_reverse(10, "back_to_back");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
